mult_div_ctrl: RTL and testbench

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

---
 rtl/mult_div_ctrl.sv | 125 ++++++++++++
 tb/tb_mult_div_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl.sv
// Multi-cycle signed MULT/DIV unit: radix-2 Booth multiply and restoring divide,
// one iteration per cycle, 32 iterations, results registered into HI/LO.
module mult_div_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic        hilo_write,
    output logic        div_zero,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  count;
    logic [64:0] work;      // MULT: {A, Q, q-1}; DIV: {remainder, quotient, unused}
    logic [31:0] m_reg;     // multiplicand (MULT) or divisor magnitude (DIV)
    logic        neg_q, neg_r;

    logic [31:0] a_mag, b_mag;
    logic [32:0] booth_sum;
    logic [64:0] mult_next, div_next;
    logic [32:0] div_shift;
    logic [31:0] rem_trial;
    logic        div_ge;
    logic        last_iter;

    assign a_mag     = a_in[31] ? (~a_in + 32'd1) : a_in;
    assign b_mag     = b_in[31] ? (~b_in + 32'd1) : b_in;
    assign last_iter = (count == 6'd31);

    // Booth add/sub is done in 33 bits so a most-negative multiplicand cannot overflow A
    always_comb begin
        booth_sum = {work[64], work[64:33]};
        case (work[1:0])
            2'b01:   booth_sum = {work[64], work[64:33]} + {m_reg[31], m_reg};
            2'b10:   booth_sum = {work[64], work[64:33]} - {m_reg[31], m_reg};
            default: booth_sum = {work[64], work[64:33]};
        endcase
        mult_next = {booth_sum, work[32:1]};
    end

    always_comb begin
        div_shift = {work[64:33], work[32]};
        div_ge    = (div_shift >= {1'b0, m_reg});
        rem_trial = div_shift[31:0] - m_reg;
        div_next  = {(div_ge ? rem_trial : div_shift[31:0]), work[31:1], div_ge, 1'b0};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_mult)                    state_nxt = MULT;
                else if (start_div && b_in != '0)  state_nxt = DIV;
            end
            MULT:    if (last_iter) state_nxt = DONE;
            DIV:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            work     <= '0;
            m_reg    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            div_zero <= (state == IDLE) && start_div && !start_mult && (b_in == '0);
            case (state)
                IDLE: begin
                    count <= '0;
                    if (start_mult) begin
                        work  <= {32'd0, b_in, 1'b0};
                        m_reg <= a_in;
                    end else if (start_div && b_in != '0) begin
                        work  <= {32'd0, a_mag, 1'b0};
                        m_reg <= b_mag;
                        neg_q <= a_in[31] ^ b_in[31];
                        neg_r <= a_in[31];
                    end
                end
                MULT: begin
                    work  <= mult_next;
                    count <= count + 6'd1;
                    if (last_iter) begin
                        hi_out <= mult_next[64:33];
                        lo_out <= mult_next[32:1];
                    end
                end
                DIV: begin
                    work  <= div_next;
                    count <= count + 6'd1;
                    if (last_iter) begin
                        hi_out <= neg_r ? (~div_next[64:33] + 32'd1) : div_next[64:33];
                        lo_out <= neg_q ? (~div_next[32:1] + 32'd1) : div_next[32:1];
                    end
                end
                default: count <= '0;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign hilo_write = (state == DONE);

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: directed operations push expected HI/LO and
// due cycles; a negedge monitor checks every done / div_zero the DUT presents.
module tb_mult_div_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        busy, done, hilo_write, div_zero;
    logic [31:0] hi_out, lo_out;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   dz_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [31:0] prev_hi = '0, prev_lo = '0;
    bit   pending_idle = 0;

    mult_div_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .hilo_write (hilo_write),
        .div_zero   (div_zero),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result or a div_zero pulse
    always @(negedge clk) begin
        if (!reset) begin
            pending_idle = 0;
        end else begin
            if (pending_idle) begin
                check("done_one_cycle", {31'd0, done}, 32'd0);
                check("busy_after_done", {31'd0, busy}, 32'd0);
                pending_idle = 0;
            end
            if (done || hilo_write) begin
                check("hilo_write_eq_done", {31'd0, hilo_write}, {31'd0, done});
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("hi_out", hi_out, e.hi);
                        check("lo_out", lo_out, e.lo);
                        check("done_cycle", cyc, e.due);
                        check("busy_in_done", {31'd0, busy}, 32'd1);
                    end
                    pending_idle = 1;
                end
            end else if (hi_out !== prev_hi || lo_out !== prev_lo) begin
                check("hilo_hold_hi", hi_out, prev_hi);
                check("hilo_hold_lo", lo_out, prev_lo);
            end
            if (div_zero) begin
                if (dz_q.size() == 0) begin
                    check("unexpected_div_zero", 32'd1, 32'd0);
                end else begin
                    int due;
                    due = dz_q.pop_front();
                    check("div_zero_cycle", cyc, due);
                    check("busy_on_div_zero", {31'd0, busy}, 32'd0);
                end
            end
        end
        prev_hi = hi_out;
        prev_lo = lo_out;
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input bit exp_res, input logic [31:0] eh, input logic [31:0] el,
                         input bit exp_dz);
        exp_t e;
        int c0;
        wait_idle();
        start_mult = m;
        start_div  = d;
        a_in       = a;
        b_in       = b;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        c0 = cyc;
        if (exp_res) begin
            e.hi  = eh;
            e.lo  = el;
            e.due = c0 + 32;
            sb.push_back(e);
        end
        if (exp_dz) dz_q.push_back(c0);
        a_in = $urandom;
        b_in = $urandom;
    endtask

    initial begin
        int n;
        exp_t e;
        #1 reset = 1'b0;
        #1;
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flags", {29'd0, done, hilo_write, div_zero}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        issue(1, 0, 32'd7,        32'hFFFFFFFD, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        issue(1, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1, 32'h3FFFFFFF, 32'h00000001, 0);
        issue(1, 0, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h00000000, 0);
        issue(0, 1, 32'hFFFFFFF9, 32'd2,        1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        issue(0, 1, 32'd100,      32'hFFFFFFF9, 1, 32'h00000002, 32'hFFFFFFF2, 0);
        issue(0, 1, 32'hFFFFFF9C, 32'hFFFFFFF9, 1, 32'hFFFFFFFE, 32'h0000000E, 0);
        // Both starts high: MULT wins (6*7), DIV would give 0 rem 6
        issue(1, 1, 32'd6,        32'd7,        1, 32'h00000000, 32'h0000002A, 0);
        issue(1, 0, 32'h66666666, 32'h2AAAAAAB, 1, 32'h11111111, 32'h22222222, 0);
        issue(0, 1, 32'd5,        32'd0,        0, 32'h0,        32'h0,        1);
        issue(0, 1, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 0);

        // start_mult while DIV busy must be ignored
        issue(0, 1, 32'd1000, 32'd3, 1, 32'h00000001, 32'h0000014D, 0);
        repeat (3) @(negedge clk);
        start_mult = 1'b1;
        a_in = 32'd9;
        b_in = 32'd9;
        @(negedge clk);
        start_mult = 1'b0;

        // Abort a MULT with reset; a mid-op start_div (b=0) must have no effect
        issue(1, 0, 32'h1234, 32'h5678, 0, 32'h0, 32'h0, 0);
        repeat (4) @(negedge clk);
        start_div = 1'b1;
        b_in = 32'd0;
        @(negedge clk);
        start_div = 1'b0;
        repeat (4) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort_hi", hi_out, 32'd0);
        check("abort_lo", lo_out, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_flags", {29'd0, done, hilo_write, div_zero}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        start_mult = 1'b1;
        a_in = 32'd3;
        b_in = 32'd5;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        e.hi  = 32'd0;
        e.lo  = 32'd15;
        e.due = cyc + 32;
        sb.push_back(e);
        check("busy_after_first_edge", {31'd0, busy}, 32'd1);

        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        check("div_zero_drained", dz_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
